// File: rtl/fp16_to_int16_conv.sv
// Half-precision to int16 converter, round toward zero. The magnitude is aligned one bit per clock.
// Latency is 2+cnt cycles from accept. A start seen while busy is dropped; there is no queueing.
module fp16_to_int16_conv #(
  parameter int BIAS   = 15,
  parameter int FRAC_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] fp_in,
  output logic [15:0] int_out,
  output logic        valid,
  output logic        busy,
  output logic        overflow,
  output logic        inexact
);

  localparam int EXP_W = 15 - FRAC_W;
  localparam logic [EXP_W-1:0] E_RMIN = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] E_LMIN = EXP_W'(BIAS + FRAC_W);
  localparam logic [EXP_W-1:0] E_MAX  = EXP_W'(2 * BIAS);
  localparam logic [EXP_W-1:0] E_ALL1 = '1;

  typedef enum logic [1:0] {IDLE, ALIGN, SIGN} state_t;

  state_t            state, state_nxt;
  logic              s_r;
  logic              dir_left;
  logic              sticky;
  logic              ovf_r;
  logic [15:0]       mag;
  logic [3:0]        cnt;

  logic              s_in;
  logic [EXP_W-1:0]  e_in;
  logic [FRAC_W-1:0] f_in;
  logic [15:0]       ld_mag;
  logic [3:0]        ld_cnt;
  logic              ld_left;
  logic              ld_sticky;
  logic              ld_ovf;

  assign s_in = fp_in[15];
  assign e_in = fp_in[14:FRAC_W];
  assign f_in = fp_in[FRAC_W-1:0];

  // Specials preload the final magnitude with cnt=0; the sign stage negates it
  // like any other result, so -32768 and the negative saturation share 0x8000.
  always_comb begin
    ld_mag    = {{(15 - FRAC_W){1'b0}}, 1'b1, f_in};
    ld_cnt    = 4'd0;
    ld_left   = 1'b0;
    ld_sticky = 1'b0;
    ld_ovf    = 1'b0;
    if (e_in == E_ALL1) begin
      ld_ovf = 1'b1;
      if (f_in != '0) ld_mag = 16'h0000;
      else            ld_mag = s_in ? 16'h8000 : 16'h7FFF;
    end else if (e_in == E_MAX) begin
      if (s_in && f_in == '0) begin
        ld_mag = 16'h8000;
      end else begin
        ld_ovf = 1'b1;
        ld_mag = s_in ? 16'h8000 : 16'h7FFF;
      end
    end else if (e_in >= E_LMIN) begin
      ld_cnt  = 4'(e_in - E_LMIN);
      ld_left = 1'b1;
    end else if (e_in >= E_RMIN) begin
      ld_cnt = 4'(E_LMIN - e_in);
    end else begin
      ld_mag    = 16'h0000;
      ld_sticky = (e_in != '0) || (f_in != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ALIGN;
      ALIGN:   if (cnt == 4'd0) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_r      <= 1'b0;
      dir_left <= 1'b0;
      sticky   <= 1'b0;
      ovf_r    <= 1'b0;
      mag      <= 16'h0000;
      cnt      <= 4'd0;
      int_out  <= 16'h0000;
      valid    <= 1'b0;
      overflow <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            s_r      <= s_in;
            mag      <= ld_mag;
            cnt      <= ld_cnt;
            dir_left <= ld_left;
            sticky   <= ld_sticky;
            ovf_r    <= ld_ovf;
          end
        end
        ALIGN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (dir_left) begin
              mag <= {mag[14:0], 1'b0};
            end else begin
              mag    <= {1'b0, mag[15:1]};
              sticky <= sticky | mag[0];
            end
          end
        end
        SIGN: begin
          int_out  <= s_r ? (~mag + 16'd1) : mag;
          overflow <= ovf_r;
          inexact  <= sticky;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp16_to_int16_conv.sv
// Directed bench for fp16_to_int16_conv: an arithmetic model predicts every result,
// and a per-cycle compare process checks valid, busy and the result fields against it.
module tb_fp16_to_int16_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] fp_in;
  logic [15:0] int_out;
  logic        valid;
  logic        busy;
  logic        overflow;
  logic        inexact;

  fp16_to_int16_conv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .fp_in    (fp_in),
    .int_out  (int_out),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow),
    .inexact  (inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] val;
    logic        ovf;
    logic        inx;
    int          lat;
  } res_t;

  typedef struct {
    logic [15:0] val;
    logic        ovf;
    logic        inx;
    int          acc;
    int          due;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Value-level model: real value = mant * 2^sh, truncated toward zero, then range-checked.
  function automatic res_t model(input logic [15:0] fp);
    res_t   r;
    logic   s;
    int     e, f, sh;
    longint mant, mv, sv;
    s     = fp[15];
    e     = int'(fp[14:10]);
    f     = int'(fp[9:0]);
    r.ovf = 1'b0;
    r.inx = 1'b0;
    r.val = 16'h0000;
    // Alignment takes one cycle per bit position between the hidden bit and bit 0.
    if (e >= 15 && e <= 24)      r.lat = 2 + (25 - e);
    else if (e >= 25 && e <= 29) r.lat = 2 + (e - 25);
    else                         r.lat = 2;
    if (e == 31) begin
      r.ovf = 1'b1;
      r.val = (f != 0) ? 16'h0000 : (s ? 16'h8000 : 16'h7FFF);
      return r;
    end
    mant = (e == 0) ? longint'(f) : longint'(1024 + f);
    sh   = (e == 0) ? -24 : e - 25;
    if (sh >= 0) begin
      mv = mant <<< sh;
    end else begin
      mv    = mant >>> (-sh);
      r.inx = ((mv <<< (-sh)) != mant);
    end
    sv = s ? -mv : mv;
    if (sv > 32767 || sv < -32768) begin
      r.ovf = 1'b1;
      r.inx = 1'b0;
      r.val = s ? 16'h8000 : 16'h7FFF;
    end else begin
      r.val = 16'(sv);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic ev, eb;
    ev = (q.size() > 0) && (q[0].due == cyc);
    eb = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].due);
    chk("valid", {15'b0, valid}, {15'b0, ev});
    chk("busy", {15'b0, busy}, {15'b0, eb});
    if (ev) begin
      chk("int_out", int_out, q[0].val);
      chk("overflow", {15'b0, overflow}, {15'b0, q[0].ovf});
      chk("inexact", {15'b0, inexact}, {15'b0, q[0].inx});
      void'(q.pop_front());
    end
  end

  // Hand-computed literals pin the model, then the op is issued and its result queued.
  task automatic issue(input logic [15:0] fp, input logic [15:0] lv,
                       input logic lo, input logic li, input int llat);
    res_t m;
    exp_t e;
    m = model(fp);
    chk("model_val", m.val, lv);
    chk("model_ovf", {15'b0, m.ovf}, {15'b0, lo});
    chk("model_inx", {15'b0, m.inx}, {15'b0, li});
    chk("model_lat", 16'(m.lat), 16'(llat));
    @(negedge clk);
    start = 1'b1;
    fp_in = fp;
    @(posedge clk);
    #1;
    start = 1'b0;
    fp_in = 16'hFFFF;
    e.val = m.val;
    e.ovf = m.ovf;
    e.inx = m.inx;
    e.acc = cyc;
    e.due = cyc + m.lat;
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 16'(q.size()), 16'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] fp;
    logic [15:0] val;
    logic        ovf;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[] = '{
    '{16'h3C00, 16'h0001, 1'b0, 1'b0, 12},
    '{16'hC100, 16'hFFFE, 1'b0, 1'b1, 11},
    '{16'h6400, 16'h0400, 1'b0, 1'b0, 2},
    '{16'h77FF, 16'h7FF0, 1'b0, 1'b0, 6},
    '{16'h7BFF, 16'h7FFF, 1'b1, 1'b0, 2},
    '{16'hF800, 16'h8000, 1'b0, 1'b0, 2},
    '{16'h7C00, 16'h7FFF, 1'b1, 1'b0, 2},
    '{16'hFC00, 16'h8000, 1'b1, 1'b0, 2},
    '{16'h7E00, 16'h0000, 1'b1, 1'b0, 2},
    '{16'h3800, 16'h0000, 1'b0, 1'b1, 2},
    '{16'h0001, 16'h0000, 1'b0, 1'b1, 2},
    '{16'h8000, 16'h0000, 1'b0, 1'b0, 2},
    '{16'h0000, 16'h0000, 1'b0, 1'b0, 2},
    '{16'hC500, 16'hFFFB, 1'b0, 1'b0, 10},
    '{16'h5A3F, 16'h00C7, 1'b0, 1'b1, 5}
  };

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fp_in = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_int_out", int_out, 16'h0000);
    chk("rst_flags", {13'b0, valid, overflow, inexact}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].fp, vecs[i].val, vecs[i].ovf, vecs[i].inx, vecs[i].lat);
      drain();
    end

    // Start while busy is dropped; start in the valid cycle is taken.
    issue(16'h3C00, 16'h0001, 1'b0, 1'b0, 12);
    repeat (3) @(negedge clk);
    start = 1'b1;
    fp_in = 16'h6400;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 20 && q.size() > 0 && cyc < q[0].due; n++) begin
      @(posedge clk);
      #1;
    end
    issue(16'h4500, 16'h0005, 1'b0, 1'b0, 10);
    drain();

    // Reset in the middle of alignment aborts without a valid pulse.
    issue(16'h3C00, 16'h0001, 1'b0, 1'b0, 12);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    #1;
    chk("abort_int_out", int_out, 16'h0000);
    chk("abort_busy", {15'b0, busy}, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(16'h4900, 16'h000A, 1'b0, 1'b0, 9);
    drain();

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
